timed_set_sequencer: RTL and testbench



---
 rtl/timed_set_sequencer_pkg.sv | 42 ++++
 rtl/timed_set_sequencer_fifo.sv | 85 ++++++++
 rtl/timed_set_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_timed_set_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timed_set_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timed_set_pkg
// Purpose  : Shared types and constants for the timed set/reset command
//            sequencer: FSM state encoding, data word width, FIFO entry
//            layout helpers.
// Revision : 1.0 - initial release
// ============================================================================
package timed_set_pkg;

  // Width of the data word forwarded to the latch with every strobe.
  localparam int DATA_W = 24;

  // State encoding, kept as explicit constants so it stays stable across tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    FIRE = ST_FIRE
  } state_e;

  // FIFO entry layout, LSB first: data | delay | mask | value.
  localparam int DATA_OFS  = 0;
  localparam int DELAY_OFS = DATA_W;

  function automatic int entry_width(input int b, input int tw);
    return 2 * b + DATA_W + tw;
  endfunction

  function automatic int mask_ofs(input int tw);
    return DATA_W + tw;
  endfunction

  function automatic int value_ofs(input int b, input int tw);
    return DATA_W + tw + b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timed_set_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : set_cmd_fifo
// Purpose  : Single-clock command FIFO. Head entry is presented
//            combinationally on dout. Pointers carry one extra bit to tell
//            full from empty on wrap.
// Revision : 1.0 - initial release
// ============================================================================
module set_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is dropped; a same-cycle pop never makes room
  // because full is a registered flag.
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  // Next pointers and status flags.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PTR_ONE;
    if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    // full follows the next pointers so a write can never overrun an entry.
    full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    // empty follows the current pointers: a freshly written entry becomes
    // visible one cycle after the write edge, which sets the fixed
    // write-to-pop distance of two edges.
    empty_d = (wptr_q == rptr_q);
  end

  // Pointer and flag registers; clear flushes everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else if (clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push && !clear) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

  assign dout  = mem_q[rptr_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule
`default_nettype wire

// File: rtl/timed_set_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : timed_set_sequencer
// Purpose  : Buffers set/reset update commands, waits a programmed delay per
//            command and issues a one-cycle set strobe with the mask-merged
//            set_data and the 24-bit data word to the downstream latch.
// Options  : TIMED_SET_ABS_TIME_EN - wr_delay becomes an absolute timestamp
//            compared against a free-running timer; adds the sticky late
//            output.
// Revision : 1.0 - initial release
// ============================================================================
module timed_set_sequencer
  import timed_set_pkg::*;
#(
  parameter int bits   = 38,
  parameter int DEPTH  = 8,
  parameter int TIME_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              run,
  input  logic              wr_en,
  input  logic [bits-1:0]   wr_value,
  input  logic [bits-1:0]   wr_mask,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TIME_W-1:0] wr_delay,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic              overflow,
  output logic              set,
  output logic [bits-1:0]   set_data,
  output logic [DATA_W-1:0] data
`ifdef TIMED_SET_ABS_TIME_EN
  ,
  output logic              late
`endif
);

  localparam int ENTRY_W   = entry_width(bits, TIME_W);
  localparam int MASK_OFS  = mask_ofs(TIME_W);
  localparam int VALUE_OFS = value_ofs(bits, TIME_W);

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;

  assign fifo_din = {wr_value, wr_mask, wr_delay, wr_data};

  set_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .push  (wr_en),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  logic [bits-1:0]   head_value;
  logic [bits-1:0]   head_mask;
  logic [TIME_W-1:0] head_delay;
  logic [DATA_W-1:0] head_data;

  assign head_data  = fifo_dout[DATA_OFS  +: DATA_W];
  assign head_delay = fifo_dout[DELAY_OFS +: TIME_W];
  assign head_mask  = fifo_dout[MASK_OFS  +: bits];
  assign head_value = fifo_dout[VALUE_OFS +: bits];

  // --------------------------------------------------------------------------
  // Sequencer state
  // --------------------------------------------------------------------------
  localparam logic [TIME_W-1:0] T_ONE = {{(TIME_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [TIME_W-1:0] cnt_q, cnt_d;        // remaining wait, or target time
  logic [bits-1:0]   cmd_value_q, cmd_value_d;
  logic [bits-1:0]   cmd_mask_q, cmd_mask_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic [bits-1:0]   shadow_q, shadow_d;  // last issued set_data
  logic [DATA_W-1:0] data_q, data_d;
  logic              set_q, set_d;
  logic              ovf_q, ovf_d;
  logic              fire_now;
  logic [TIME_W-1:0] cnt_next_wait;

`ifdef TIMED_SET_ABS_TIME_EN
  logic [TIME_W-1:0] timer_q, timer_d;
  logic              late_q, late_d;
  logic [TIME_W-1:0] wait_elapsed;
  logic [TIME_W-1:0] head_elapsed;
  logic              head_late;

  // Signed distance from the target: MSB clear means the target is reached.
  assign wait_elapsed  = timer_q - cnt_q;
  assign head_elapsed  = timer_q - head_delay;
  assign fire_now      = !wait_elapsed[TIME_W-1];
  assign head_late     = !head_elapsed[TIME_W-1] && (head_elapsed != '0);
  assign cnt_next_wait = cnt_q;
  assign timer_d       = timer_q + T_ONE;
`else
  // Relative delay: count down to zero, never wrapping below it.
  assign fire_now      = (cnt_q == '0);
  assign cnt_next_wait = cnt_q - T_ONE;
`endif

  // Sticky flag for commands dropped against a full FIFO.
  assign ovf_d = ovf_q | (wr_en & fifo_full);

  // Next-state logic: pop in IDLE, count in WAIT, strobe for one FIRE cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_value_d = cmd_value_q;
    cmd_mask_d  = cmd_mask_q;
    cmd_data_d  = cmd_data_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    set_d       = 1'b0;
    fifo_pop    = 1'b0;
`ifdef TIMED_SET_ABS_TIME_EN
    late_d      = late_q;
`endif
    case (state_q)
      IDLE: begin
        if (run && !fifo_empty) begin
          fifo_pop    = 1'b1;
          cnt_d       = head_delay;
          cmd_value_d = head_value;
          cmd_mask_d  = head_mask;
          cmd_data_d  = head_data;
          state_d     = WAIT;
`ifdef TIMED_SET_ABS_TIME_EN
          if (head_late) late_d = 1'b1;
`endif
        end
      end
      WAIT: begin
        if (fire_now) begin
          // Strobe and payload are registered together so set_data and data
          // are already valid in the cycle set is high.
          state_d  = FIRE;
          set_d    = 1'b1;
          shadow_d = (shadow_q & ~cmd_mask_q) | (cmd_value_q & cmd_mask_q);
          data_d   = cmd_data_q;
        end else begin
          cnt_d = cnt_next_wait;
        end
      end
      FIRE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; clear discards queued and in-flight work without a strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_value_q <= '0;
      cmd_mask_q  <= '0;
      cmd_data_q  <= '0;
      shadow_q    <= '0;
      data_q      <= '0;
      set_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_value_q <= '0;
      cmd_mask_q  <= '0;
      cmd_data_q  <= '0;
      shadow_q    <= '0;
      data_q      <= '0;
      set_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_value_q <= cmd_value_d;
      cmd_mask_q  <= cmd_mask_d;
      cmd_data_q  <= cmd_data_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      set_q       <= set_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef TIMED_SET_ABS_TIME_EN
  // Free-running timestamp base and sticky late flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      late_q  <= 1'b0;
    end else if (clear) begin
      timer_q <= '0;
      late_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      late_q  <= late_d;
    end
  end

  assign late = late_q;
`endif

  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;
  assign set      = set_q;
  assign set_data = shadow_q;
  assign data     = data_q;

endmodule
`default_nettype wire

// File: tb/tb_timed_set_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_timed_set_sequencer
// Purpose  : Scoreboard bench for timed_set_sequencer (relative-delay build).
//            Stimulus tasks push expected strobes; a negedge monitor pops and
//            compares them when set is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timed_set_sequencer;

  localparam int BITS   = 38;
  localparam int DEPTH  = 8;
  localparam int TIME_W = 32;
  localparam int DW     = 24;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic              run   = 1'b0;
  logic              wr_en = 1'b0;
  logic [BITS-1:0]   wr_value = '0;
  logic [BITS-1:0]   wr_mask  = '0;
  logic [DW-1:0]     wr_data  = '0;
  logic [TIME_W-1:0] wr_delay = '0;
  logic              full, empty, busy, overflow, set;
  logic [BITS-1:0]   set_data;
  logic [DW-1:0]     data;

  timed_set_sequencer #(
    .bits   (BITS),
    .DEPTH  (DEPTH),
    .TIME_W (TIME_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .run      (run),
    .wr_en    (wr_en),
    .wr_value (wr_value),
    .wr_mask  (wr_mask),
    .wr_data  (wr_data),
    .wr_delay (wr_delay),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .overflow (overflow),
    .set      (set),
    .set_data (set_data),
    .data     (data)
  );

  always #5 clock = ~clock;

  int ecnt = 0;  // index of the most recent rising edge
  always @(posedge clock) ecnt++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: expected strobes with their edge index.
  // A command written at edge w pops at the first edge >= w+2 that is also
  // >= previous strobe edge + 2 and has run high; it strobes pop+delay+1.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [BITS-1:0] sd;
    logic [DW-1:0]   d;
    int              w;
    int              dly;
    int              pop;
    int              fire;
  } item_t;

  item_t           sbq[$];      // scheduled, awaiting strobe
  item_t           unsched[$];  // queued while run is low
  logic [BITS-1:0] m_shadow = '0;
  logic [BITS-1:0] m_out_sd = '0;
  logic [DW-1:0]   m_out_d  = '0;
  logic            m_ovf    = 1'b0;
  int              m_last_fire = -100;
  int              m_run_edge  = 0;
  bit              m_run = 1'b0;

  function automatic void schedule_item(item_t it);
    int p;
    p = it.w + 2;
    if (m_last_fire + 2 > p) p = m_last_fire + 2;
    if (m_run_edge > p) p = m_run_edge;
    it.pop  = p;
    it.fire = p + it.dly + 1;
    m_last_fire = it.fire;
    sbq.push_back(it);
  endfunction

  // Entries still held in the FIFO just before edge W.
  function automatic int occ_at(input int W);
    int n;
    n = unsched.size();
    foreach (sbq[i]) if (sbq[i].pop >= W) n++;
    return n;
  endfunction

  function automatic void model_flush();
    sbq.delete();
    unsched.delete();
    m_shadow    = '0;
    m_out_sd    = '0;
    m_out_d     = '0;
    m_ovf       = 1'b0;
    m_last_fire = -100;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus tasks (called just after a rising edge)
  // --------------------------------------------------------------------------
  task automatic do_write(input logic [BITS-1:0] v, input logic [BITS-1:0] m,
                          input logic [DW-1:0] d, input int dly);
    item_t it;
    int    W;
    W        = ecnt + 1;
    wr_en    = 1'b1;
    wr_value = v;
    wr_mask  = m;
    wr_data  = d;
    wr_delay = dly;
    chk("full_at_write", {63'd0, full}, {63'd0, occ_at(W) == DEPTH});
    if (occ_at(W) < DEPTH) begin
      it.sd    = (m_shadow & ~m) | (v & m);
      m_shadow = it.sd;
      it.d     = d;
      it.w     = W;
      it.dly   = dly;
      it.pop   = 0;
      it.fire  = 0;
      if (m_run) schedule_item(it);
      else unsched.push_back(it);
    end else begin
      m_ovf = 1'b1;
    end
    @(posedge clock); #1;
    wr_en = 1'b0;
  endtask

  task automatic set_run(input bit r);
    run = r;
    if (r && !m_run) begin
      m_run      = 1'b1;
      m_run_edge = ecnt + 1;
      while (unsched.size() > 0) schedule_item(unsched.pop_front());
    end
    if (!r) m_run = 1'b0;
  endtask

  task automatic do_clear(input bit with_wr);
    clear = 1'b1;
    if (with_wr) begin
      wr_en    = 1'b1;
      wr_value = '1;
      wr_mask  = '1;
      wr_data  = 24'h5A5A5A;
      wr_delay = '0;
    end
    @(posedge clock); #1;
    clear = 1'b0;
    wr_en = 1'b0;
    model_flush();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while ((sbq.size() > 0 || unsched.size() > 0) && n < bound) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_pending", 64'(sbq.size() + unsched.size()), 64'd0);
    idle(4);
    chk("busy_after_drain", {63'd0, busy}, 64'd0);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: compare every strobe and the held outputs between strobes
  // --------------------------------------------------------------------------
  always @(negedge clock) begin
    item_t e;
    if (!reset) begin
      if (set) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: set=1 at edge %0d, expected set=0", ecnt);
        end else begin
          e = sbq.pop_front();
          chk("strobe_edge", 64'(ecnt), 64'(e.fire));
          chk("strobe_set_data", {26'd0, set_data}, {26'd0, e.sd});
          chk("strobe_data", {40'd0, data}, {40'd0, e.d});
          m_out_sd = e.sd;
          m_out_d  = e.d;
        end
      end else begin
        if (sbq.size() > 0 && sbq[0].fire <= ecnt) begin
          e = sbq.pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL missing_strobe: set=0 at edge %0d, required set=1 at edge %0d", ecnt, e.fire);
        end
        chk("hold_set_data", {26'd0, set_data}, {26'd0, m_out_sd});
        chk("hold_data", {40'd0, data}, {40'd0, m_out_d});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [63:0] r64;
    logic [BITS-1:0] rv, rm;

    idle(3);
    // Reset state
    chk("rst_set", {63'd0, set}, 64'd0);
    chk("rst_set_data", {26'd0, set_data}, 64'd0);
    chk("rst_data", {40'd0, data}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full", {63'd0, full}, 64'd0);
    reset = 1'b0;
    idle(2);

    // Single command: strobe 8 edges after the write edge
    set_run(1'b1);
    do_write(38'h15, '1, 24'hABCDEF, 5);
    wait_drain(50);

    // Partial mask merge, back-to-back zero delays
    do_write('1, '1, 24'h000001, 0);
    do_write('0, 38'h0F, 24'h000002, 0);
    wait_drain(50);

    // Reset in the middle of a long wait
    do_write(38'h2A, '1, 24'h123456, 100);
    idle(50);
    chk("busy_in_wait", {63'd0, busy}, {63'd0, (sbq.size() > 0) && (ecnt >= sbq[0].pop)});
    #3;
    reset = 1'b1;
    model_flush();
    #1;
    chk("rstw_set", {63'd0, set}, 64'd0);
    chk("rstw_set_data", {26'd0, set_data}, 64'd0);
    chk("rstw_data", {40'd0, data}, 64'd0);
    chk("rstw_busy", {63'd0, busy}, 64'd0);
    chk("rstw_empty", {63'd0, empty}, 64'd1);
    idle(2);
    reset = 1'b0;
    idle(120);
    do_write(38'h3, 38'h3, 24'h00BEEF, 3);
    wait_drain(50);

    // Overflow: fill while stopped, drop the ninth, then drain in order
    set_run(1'b0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      do_write(38'(i + 1), '1, 24'(24'h100 + i), i % 3);
    end
    chk("ovf_full", {63'd0, full}, 64'd1);
    chk("ovf_flag", {63'd0, overflow}, {63'd0, m_ovf});
    chk("ovf_empty", {63'd0, empty}, 64'd0);
    set_run(1'b1);
    wait_drain(200);
    chk("ovf_sticky", {63'd0, overflow}, {63'd0, m_ovf});
    do_clear(1'b0);
    chk("clr_overflow", {63'd0, overflow}, 64'd0);
    chk("clr_empty", {63'd0, empty}, 64'd1);

    // Clear against a same-cycle write with three commands queued
    set_run(1'b0);
    do_write('1, '1, 24'h0000A1, 1);
    do_write('1, '1, 24'h0000A2, 1);
    do_write('1, '1, 24'h0000A3, 1);
    do_clear(1'b1);
    chk("cw_empty", {63'd0, empty}, 64'd1);
    chk("cw_full", {63'd0, full}, 64'd0);
    chk("cw_set_data", {26'd0, set_data}, 64'd0);
    set_run(1'b1);
    idle(20);
    do_write('1, 38'h0F, 24'h0000C0, 2);
    wait_drain(50);

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      idle($urandom_range(0, 6));
      r64 = {$urandom, $urandom};
      rv  = r64[BITS-1:0];
      r64 = {$urandom, $urandom};
      rm  = r64[BITS-1:0];
      do_write(rv, rm, 24'($urandom), $urandom_range(0, 10));
    end
    wait_drain(2000);
    chk("rand_overflow", {63'd0, overflow}, {63'd0, m_ovf});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
